// File: rtl/irq_ctrl_pkg.sv
// Shared register map, state encoding and CTRL bit layout for the interrupt controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Consumed by irq_controller and irq_prio_enc through import irq_ctrl_pkg::*.
package irq_ctrl_pkg;

    localparam int unsigned MAX_SRC  = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned NUM_REGS = 5;

    localparam logic [7:0] OFF_PENDING = 8'd0;
    localparam logic [7:0] OFF_MASK    = 8'd1;
    localparam logic [7:0] OFF_VECTOR  = 8'd2;
    localparam logic [7:0] OFF_CTRL    = 8'd3;
    localparam logic [7:0] OFF_EOI     = 8'd4;

    localparam int unsigned CTRL_EN_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAISE   = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    function automatic logic [MAX_SRC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return MAX_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending vector.
// Latency: combinational. Backpressure: none.
// vld is low and idx is 0 when no request bit is set.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]     req_vec,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Bus-mapped interrupt controller: edge-detected sources, mask, priority raise/ack/EOI FSM.
// Latency: edge->PENDING 1 clk, PENDING->CPU_IRQ 1 clk (+2 with IRQ_CTRL_SYNC_EN); reads return 1 clk after address.
// Backpressure: none; CPU_IRQ holds until CPU_IRQ_ACK, further raises wait for an EOI write.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'hE0,
    parameter int unsigned NUM_SRC   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         BUS_ADDR,
    inout  wire  [7:0]         BUS_DATA,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    output logic               CPU_IRQ,
    input  logic               CPU_IRQ_ACK
);

    logic [NUM_SRC-1:0] irq_s;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int unsigned PRIME_LEN = 3;
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= IRQ_IN;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    localparam int unsigned PRIME_LEN = 1;
    assign irq_s = IRQ_IN;
`endif

    // Edge detection stays off until the history holds a real input sample,
    // so sources already high at reset release do not register as edges.
    logic [PRIME_LEN-1:0] prime_q;
    logic [NUM_SRC-1:0]   hist_q;
    logic                 edge_ok;
    logic [NUM_SRC-1:0]   rise;

    assign edge_ok = prime_q[PRIME_LEN-1];
    assign rise    = edge_ok ? (irq_s & ~hist_q) : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prime_q <= '0;
            hist_q  <= '0;
        end else begin
            prime_q <= PRIME_LEN'({prime_q, 1'b1});
            hist_q  <= irq_s;
        end
    end

    logic [7:0] bus_off;
    logic       bus_hit;
    logic       wr_pend;
    logic       wr_mask;
    logic       wr_ctrl;
    logic       wr_eoi;
    logic [7:0] wr_dat;

    assign bus_off = BUS_ADDR - BASE_ADDR;
    assign bus_hit = bus_off < 8'(NUM_REGS);
    assign wr_dat  = BUS_DATA;
    assign wr_pend = bus_hit && BUS_WE && (bus_off == OFF_PENDING);
    assign wr_mask = bus_hit && BUS_WE && (bus_off == OFF_MASK);
    assign wr_ctrl = bus_hit && BUS_WE && (bus_off == OFF_CTRL);
    assign wr_eoi  = bus_hit && BUS_WE && (bus_off == OFF_EOI);

    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] mask_q;
    logic               ctrl_en_q;
    logic [IDX_W-1:0]   vector_q;
    irq_state_t         state_q;

    // Arbitration sees this cycle's bus writes, so a clear, mask or disable
    // takes effect on CPU_IRQ at the same edge that captures the write.
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] mask_eff;
    logic               en_eff;
    logic [NUM_SRC-1:0] cand;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;

    assign pend_clr = wr_pend ? wr_dat[NUM_SRC-1:0] : '0;
    assign mask_eff = wr_mask ? wr_dat[NUM_SRC-1:0] : mask_q;
    assign en_eff   = wr_ctrl ? wr_dat[CTRL_EN_BIT] : ctrl_en_q;
    assign cand     = pend_q & ~pend_clr & mask_eff;

    irq_prio_enc #(
        .N (NUM_SRC)
    ) u_prio_enc (
        .req_vec (cand),
        .idx     (win_idx),
        .vld     (win_vld)
    );

    logic               raise_go;
    logic               raise_abort;
    logic               ack_fire;
    logic [MAX_SRC-1:0] win_onehot;
    logic [NUM_SRC-1:0] ack_clr;

    assign raise_go    = (state_q == ST_IDLE) && en_eff && win_vld;
    assign raise_abort = (state_q == ST_RAISE) && !(en_eff && win_vld);
    assign ack_fire    = (state_q == ST_RAISE) && en_eff && win_vld && CPU_IRQ_ACK;
    assign win_onehot  = idx_onehot(win_idx);
    assign ack_clr     = ack_fire ? win_onehot[NUM_SRC-1:0] : '0;

    // A new edge wins over any clear hitting the same bit in the same cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_q    <= '0;
            mask_q    <= '0;
            ctrl_en_q <= 1'b0;
        end else begin
            pend_q    <= (pend_q & ~pend_clr & ~ack_clr) | rise;
            mask_q    <= mask_eff;
            ctrl_en_q <= en_eff;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            CPU_IRQ  <= 1'b0;
            vector_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (raise_go) begin
                        state_q <= ST_RAISE;
                        CPU_IRQ <= 1'b1;
                    end
                end
                ST_RAISE: begin
                    if (raise_abort) begin
                        state_q <= ST_IDLE;
                        CPU_IRQ <= 1'b0;
                    end else if (ack_fire) begin
                        state_q  <= ST_SERVICE;
                        CPU_IRQ  <= 1'b0;
                        vector_q <= win_idx;
                    end
                end
                ST_SERVICE: begin
                    if (wr_eoi) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    CPU_IRQ <= 1'b0;
                end
            endcase
        end
    end

    logic [7:0] rd_mux;
    logic [7:0] rd_dat_q;
    logic       rd_vld_q;

    always_comb begin
        rd_mux = 8'h00;
        case (bus_off)
            OFF_PENDING: rd_mux = 8'(pend_q);
            OFF_MASK:    rd_mux = 8'(mask_q);
            OFF_VECTOR:  rd_mux = 8'(vector_q);
            OFF_CTRL:    rd_mux = {7'b0, ctrl_en_q};
            default:     rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= 8'h00;
        end else begin
            rd_vld_q <= bus_hit && !BUS_WE;
            rd_dat_q <= rd_mux;
        end
    end

    assign BUS_DATA = rd_vld_q ? rd_dat_q : 8'hzz;

endmodule
